// File: rtl/iob_uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive FIFO.
package iob_uart_rx_fifo_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/iob_ram_2p.sv
// Two-port RAM: one synchronous write port and one asynchronous read port.
module iob_ram_2p #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/iob_uart_rx_fifo.sv
// Drains received bytes from uart_core into a first-word-fall-through FIFO.
// Define IOB_UART_RX_FIFO_LEVEL_EN to add the level_o / afull_o occupancy outputs.
module iob_uart_rx_fifo
  import iob_uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              rst_soft_i,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              data_read_en_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic              ovf_o,
  input  logic              ovf_clr_i
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_W:0]  level_o,
  output logic              afull_o
`endif
);

  localparam logic [DEPTH_W:0] PtrOne = {{DEPTH_W{1'b0}}, 1'b1};

  rd_state_e        state_q, state_d;
  logic             rd_en_q;
  logic [DEPTH_W:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, push, pop, push_ok, drop;

  // GAP keeps a stale rx_ready from triggering a second read of the same byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_ready_i) state_d = READ;
      READ:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_soft_i) state_d = IDLE;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                 (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
  assign pop   = !empty && m_ready_i;
  assign push  = (state_q == READ);
  // Fullness is judged after a same-cycle pop has freed a slot.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (rst_soft_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q  <= IDLE;
      rd_en_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= (state_d == READ);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  iob_ram_2p #(
    .ADDR_W (DEPTH_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i    (clk_i),
    .w_en_i   (push_ok && !rst_soft_i),
    .w_addr_i (wr_ptr_q[DEPTH_W-1:0]),
    .w_data_i (rx_data_i),
    .r_addr_i (rd_ptr_q[DEPTH_W-1:0]),
    .r_data_o (m_data_o)
  );

  assign data_read_en_o = rd_en_q;
  assign m_valid_o      = !empty;
  assign ovf_o          = ovf_q;

`ifdef IOB_UART_RX_FIFO_LEVEL_EN
  logic [DEPTH_W:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (rst_soft_i) begin
      level_d = '0;
    end else if (push_ok && !pop) begin
      level_d = level_q + PtrOne;
    end else if (pop && !push_ok) begin
      level_d = level_q - PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign afull_o = (32'(level_q) >= AFULL_LVL);
`endif

endmodule

// File: tb/tb_iob_uart_rx_fifo.sv
// Randomized bench for iob_uart_rx_fifo against a queue-based reference model.
module tb_iob_uart_rx_fifo;

  localparam int DepthW   = 4;
  localparam int Depth    = 16;
  localparam int AfullLvl = 12;

  typedef logic [7:0] u8_t;

  logic       clk_i = 1'b0;
  logic       arst_i, rst_soft_i, rx_ready_i;
  logic [7:0] rx_data_i;
  logic       data_read_en_o, m_valid_o;
  logic [7:0] m_data_o;
  logic       m_ready_i, ovf_o, ovf_clr_i;
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
  logic [DepthW:0] level_o;
  logic            afull_o;
`endif

  always #5 clk_i = ~clk_i;

  iob_uart_rx_fifo #(
    .DEPTH_W   (DepthW),
    .AFULL_LVL (AfullLvl)
  ) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .rst_soft_i     (rst_soft_i),
    .rx_ready_i     (rx_ready_i),
    .rx_data_i      (rx_data_i),
    .data_read_en_o (data_read_en_o),
    .m_valid_o      (m_valid_o),
    .m_data_o       (m_data_o),
    .m_ready_i      (m_ready_i),
    .ovf_o          (ovf_o),
    .ovf_clr_i      (ovf_clr_i)
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
    ,
    .level_o        (level_o),
    .afull_o        (afull_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, sticky flag, and read-strobe timing.
  u8_t mq[$];
  bit  m_ovf, m_strobe;
  int  m_hold;

  // Byte source emulating uart_core: rx_ready lingers one cycle after the strobe.
  u8_t src[$];
  bit  consumed, stale_left;

  int  ready_mode;  // 0 low, 1 high, 2 random, 3 only during a strobe cycle
  bit  clr_pulse, clr_on_strobe;
  int  arst_req, arst_hold, soft_req;
  u8_t rx_log[$];
  u8_t exp_q[$];
  int  strobe_cnt, sc0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_strobe = 1'b0;
    m_hold   = 0;
  endtask

  task automatic step();
    logic pop_b, push_b, drop_b;
    u8_t  b;
    @(negedge clk_i);
    check_eq("strobe", data_read_en_o, m_strobe);
    check_eq("valid", m_valid_o, mq.size() != 0);
    if (mq.size() != 0) check_eq("data", m_data_o, mq[0]);
    check_eq("ovf", ovf_o, m_ovf);
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
    check_eq("level", level_o, mq.size());
    check_eq("afull", afull_o, mq.size() >= AfullLvl);
`endif
    if (data_read_en_o) strobe_cnt++;

    if (data_read_en_o) begin
      consumed   = 1'b1;
      stale_left = 1'b1;
    end else if (stale_left) begin
      stale_left = 1'b0;
    end else begin
      if (consumed) begin
        void'(src.pop_front());
        consumed = 1'b0;
      end
      rx_ready_i = (src.size() != 0);
      rx_data_i  = (src.size() != 0) ? src[0] : 8'($urandom);
    end

    rst_soft_i = 1'b0;
    if (soft_req == 1 && m_hold == 1 && !m_strobe) begin
      rst_soft_i = 1'b1;
      soft_req   = 0;
    end else if (soft_req == 2 && m_strobe) begin
      rst_soft_i = 1'b1;
      soft_req   = 0;
      stale_left = 1'b0;
    end

    case (ready_mode)
      0:       m_ready_i = 1'b0;
      1:       m_ready_i = 1'b1;
      2:       m_ready_i = 1'($urandom_range(0, 1));
      default: m_ready_i = m_strobe;
    endcase
    ovf_clr_i = clr_pulse || (clr_on_strobe && m_strobe);
    clr_pulse = 1'b0;

    if (arst_hold > 0) begin
      arst_hold--;
      if (arst_hold == 0) arst_i = 1'b1;
    end else if (arst_req != 0 && m_hold == 1 && !m_strobe) begin
      check_eq("pre_arst_valid", m_valid_o, 1);
      arst_req  = 0;
      arst_i    = 1'b0;
      arst_hold = 3;
      #1;
      check_eq("arst_valid", m_valid_o, 0);
      check_eq("arst_strobe", data_read_en_o, 0);
    end

    if (arst_i && !rst_soft_i && m_valid_o && m_ready_i) rx_log.push_back(m_data_o);

    if (!arst_i || rst_soft_i) begin
      model_reset();
    end else begin
      pop_b  = (mq.size() != 0) && m_ready_i;
      push_b = m_strobe;
      b      = rx_data_i;
      drop_b = 1'b0;
      if (pop_b) void'(mq.pop_front());
      if (push_b) begin
        if (mq.size() < Depth) mq.push_back(b);
        else drop_b = 1'b1;
      end
      if (drop_b) m_ovf = 1'b1;
      else if (ovf_clr_i) m_ovf = 1'b0;
      if (m_strobe) begin
        m_strobe = 1'b0;
        m_hold   = 1;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_strobe = rx_ready_i;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 4000 && !(src.size() == 0 && !consumed && !stale_left && m_hold == 0 &&
                         !m_strobe && arst_hold == 0 && arst_req == 0 && soft_req == 0)) begin
      step();
      n++;
    end
    if (n >= 4000) check_eq({tag, "_timeout"}, 1, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_mode = 1;
    while (n < 4000 && mq.size() != 0) begin
      step();
      n++;
    end
    if (n >= 4000) check_eq({tag, "_timeout"}, 1, 0);
    ready_mode = 0;
    step();
  endtask

  task automatic fill(input u8_t base);
    ready_mode = 0;
    for (int i = 0; i < Depth; i++) src.push_back(base + 8'(i));
    wait_done("fill");
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    arst_i = 1'b1; rst_soft_i = 1'b0; rx_ready_i = 1'b0; rx_data_i = 8'h00;
    m_ready_i = 1'b0; ovf_clr_i = 1'b0;
    ready_mode = 0; clr_pulse = 0; clr_on_strobe = 0;
    arst_req = 0; soft_req = 0; strobe_cnt = 0;
    consumed = 0; stale_left = 0;
    model_reset();
    #1 arst_i = 1'b0;
    arst_hold = 3;
    repeat (5) step();
    check_eq("rst_valid", m_valid_o, 0);
    check_eq("rst_ovf", ovf_o, 0);

    // Stream 0x00..0xFF with the sink always ready.
    ready_mode = 1;
    rx_log.delete();
    sc0 = strobe_cnt;
    for (int i = 0; i < 256; i++) src.push_back(8'(i));
    wait_done("stream");
    repeat (3) step();
    check_eq("stream_cnt", rx_log.size(), 256);
    for (int i = 0; i < rx_log.size() && i < 256; i++) check_eq("stream_byte", rx_log[i], 32'(i));
    check_eq("stream_strobes", strobe_cnt - sc0, 256);
    check_eq("stream_ovf", ovf_o, 0);

    // Fill to full with the sink stalled.
    fill(8'hA0);
    check_eq("fill_valid", m_valid_o, 1);
    check_eq("fill_head", m_data_o, 8'hA0);
    check_eq("fill_ovf", ovf_o, 0);
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
    check_eq("fill_level", level_o, 16);
    check_eq("fill_afull", afull_o, 1);
`endif

    // Overflow from full: byte consumed from uart_core, dropped from the FIFO.
    sc0 = strobe_cnt;
    src.push_back(8'h55);
    wait_done("ovf");
    step();
    check_eq("ovf_strobe", strobe_cnt - sc0, 1);
    check_eq("ovf_set", ovf_o, 1);
    check_eq("ovf_head", m_data_o, 8'hA0);
    rx_log.delete();
    drain("ovf_drain");
    check_eq("ovf_drain_cnt", rx_log.size(), 16);
    for (int i = 0; i < rx_log.size() && i < 16; i++) check_eq("ovf_drain_byte", rx_log[i], 32'hA0 + i);
    check_eq("ovf_sticky", ovf_o, 1);
    clr_pulse = 1'b1;
    step();
    step();
    check_eq("ovf_clr", ovf_o, 0);

    // Clear coinciding with a new overflow keeps the flag set.
    fill(8'hC0);
    clr_on_strobe = 1'b1;
    src.push_back(8'h66);
    wait_done("clr_ovf");
    clr_on_strobe = 1'b0;
    step();
    check_eq("clr_ovf_same", ovf_o, 1);
    clr_pulse = 1'b1;
    drain("clr_ovf_drain");
    check_eq("clr_ovf_cleared", ovf_o, 0);

    // Push lands on a full FIFO in the same cycle as a pop.
    fill(8'hB0);
    rx_log.delete();
    ready_mode = 3;
    src.push_back(8'h77);
    wait_done("simul");
    ready_mode = 0;
    step();
    check_eq("simul_ovf", ovf_o, 0);
    check_eq("simul_head", m_data_o, 8'hB1);
`ifdef IOB_UART_RX_FIFO_LEVEL_EN
    check_eq("simul_level", level_o, 16);
`endif
    drain("simul_drain");
    check_eq("simul_cnt", rx_log.size(), 17);
    if (rx_log.size() == 17) check_eq("simul_last", rx_log[16], 8'h77);

    // Pointer wrap with random back-pressure.
    rx_log.delete();
    exp_q.delete();
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'($urandom));
      src.push_back(exp_q[i]);
    end
    wait_done("wrap");
    drain("wrap_drain");
    check_eq("wrap_cnt", rx_log.size(), 40);
    for (int i = 0; i < rx_log.size() && i < 40; i++) check_eq("wrap_byte", rx_log[i], exp_q[i]);

    // Asynchronous reset during GAP with bytes queued.
    for (int i = 0; i < 4; i++) src.push_back(8'h10 + 8'(i));
    wait_done("arst_pre");
    arst_req = 1;
    src.push_back(8'h14);
    wait_done("arst");
    step();
    check_eq("arst_empty", m_valid_o, 0);
    src.push_back(8'h3C);
    wait_done("arst_post");
    step();
    check_eq("arst_next_valid", m_valid_o, 1);
    check_eq("arst_next_data", m_data_o, 8'h3C);
    drain("arst_drain");

    // Synchronous soft reset during GAP.
    for (int i = 0; i < 4; i++) src.push_back(8'h20 + 8'(i));
    wait_done("soft_pre");
    soft_req = 1;
    src.push_back(8'h24);
    wait_done("soft");
    step();
    check_eq("soft_empty", m_valid_o, 0);
    src.push_back(8'h3D);
    wait_done("soft_post");
    step();
    check_eq("soft_next_data", m_data_o, 8'h3D);
    drain("soft_drain");

    // Soft reset while the strobe is out: byte lost, no overflow.
    src.push_back(8'h01);
    wait_done("softr_pre");
    soft_req = 2;
    src.push_back(8'h99);
    wait_done("softr");
    step();
    check_eq("softr_empty", m_valid_o, 0);
    check_eq("softr_ovf", ovf_o, 0);
    src.push_back(8'h3E);
    wait_done("softr_post");
    step();
    check_eq("softr_next_data", m_data_o, 8'h3E);
    drain("softr_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_uart_rx_fifo.md
IOB_UART_RX_FIFO -- requirements
Module: iob_uart_rx_fifo

Interface
REQ-001 Parameter DEPTH_W, default 4: log2 of FIFO depth, 16 entries.
REQ-002 Parameter AFULL_LVL, default 12: almost-full threshold, used only with the configuration macro enabled.
REQ-003 clk_i  input  1  system clock; all logic on the rising edge.
REQ-004 arst_i  input  1  reset, asynchronous and active-low.
REQ-005 rst_soft_i  input  1  synchronous soft reset, active-high.
REQ-006 rx_ready_i  input  1  uart_core has a received byte (from rx_ready_o).
REQ-007 rx_data_i  input  8  uart_core received byte (from rx_data_o).
REQ-008 data_read_en_o  output  1  read strobe to uart_core (to data_read_en_i).
REQ-009 m_valid_o  output  1  byte available downstream.
REQ-010 m_data_o  output  8  head byte, first-word-fall-through.
REQ-011 m_ready_i  input  1  downstream accepts the head byte.
REQ-012 ovf_o  output  1  sticky overflow: a byte was dropped.
REQ-013 ovf_clr_i  input  1  clears ovf_o.

Function
REQ-014 The read FSM SHALL have exactly these states: IDLE, READ, GAP.
- IDLE -> READ when rx_ready_i=1.
- READ -> GAP unconditionally.
- GAP -> IDLE unconditionally.
REQ-015 data_read_en_o SHALL be registered and high for exactly the one cycle spent in READ.
REQ-016 rx_data_i SHALL be sampled at the end of the READ cycle.
REQ-017 The sampled byte SHALL be pushed into the FIFO on that same edge.
REQ-018 Push-to-visible latency SHALL be 1 cycle: m_valid_o rises in the cycle after READ when the FIFO was empty.
REQ-019 GAP SHALL block re-reading one byte twice while uart_core drops rx_ready after the strobe.
- Minimum spacing between data_read_en_o pulses is 3 cycles.
REQ-020 m_valid_o SHALL equal "FIFO not empty".
REQ-021 m_data_o SHALL present the entry at the read pointer combinationally from storage.
REQ-022 A pop SHALL occur when m_valid_o=1 and m_ready_i=1.
REQ-023 A pop SHALL advance the read pointer at that clock edge.
REQ-024 The full condition at a push SHALL be evaluated after any pop in the same cycle.
- A push with a simultaneous pop while full is accepted.
- The count stays at 2**DEPTH_W.
REQ-025 A push when full with no pop SHALL drop the byte.
- The FIFO is not modified.
- ovf_o is set on the next edge.
- The uart_core byte is still consumed, so the read strobe is issued.
REQ-026 ovf_o SHALL stay at 1 until ovf_clr_i=1.
- When a clear and a new overflow occur in the same cycle, ovf_o stays 1.
REQ-027 Pointers SHALL be DEPTH_W+1 bits and wrap modulo 2**(DEPTH_W+1).
- empty when the pointers are equal.
- full when the MSBs differ and the remaining bits are equal.
REQ-028 Pop when empty SHALL be impossible by construction, since m_valid_o=0.
REQ-029 m_ready_i while empty SHALL have no effect.

Reset
REQ-030 While arst_i=0, the block SHALL hold this state:
- FSM in IDLE.
- pointers at 0.
- data_read_en_o=0, m_valid_o=0, ovf_o=0.
- m_data_o is don't-care; storage contents are not reset.
REQ-031 rst_soft_i=1 SHALL return the same state as arst_i on the next edge and override push and pop in that cycle.
- A read in progress (READ or GAP) is abandoned.
- A strobe already issued loses its byte silently, without setting ovf_o.

Configuration
REQ-032 With IOB_UART_RX_FIFO_LEVEL_EN defined, the block SHALL add these outputs:
- level_o, output, DEPTH_W+1 bits: registered occupancy count, 0..2**DEPTH_W, updated on the same edge as the pointers.
- afull_o, output, 1 bit: (level_o >= AFULL_LVL).
- Both reset to 0.
REQ-033 Without IOB_UART_RX_FIFO_LEVEL_EN, the block SHALL not declare level_o, afull_o, or the count register, and all other behaviour is identical.

Structure
REQ-034 A shared package iob_uart_rx_fifo_pkg SHALL hold:
- the FSM state encoding (IDLE=2'd0, READ=2'd1, GAP=2'd2).
- the data width constant (8).
REQ-035 Storage SHALL be one sub-module, iob_ram_2p: one write port, one asynchronous read port, depth 2**DEPTH_W by 8.

Verification
REQ-036 Stream: uart_core looped back at div=100, sending bytes 0x00..0xFF, m_ready_i=1 -> 256 bytes out in order, ovf_o=0, each strobe exactly 1 cycle.
REQ-037 Fill: m_ready_i=0, send 16 bytes 0xA0..0xAF -> full, m_valid_o=1, m_data_o=0xA0; with the macro, level_o=16 and afull_o=1 from the 12th byte on.
REQ-038 Overflow: from full, send 0x55 -> strobe issued, ovf_o=1, FIFO unchanged; drain yields 0xA0..0xAF and no 0x55; ovf_clr_i pulse -> ovf_o=0.
REQ-039 Simultaneous: FIFO full, m_ready_i=1 in the cycle the push lands -> 0x77 accepted as the 16th entry, ovf_o=0.
REQ-040 Wrap: 40 bytes pushed and popped with random m_ready_i -> pointers wrap twice, data order preserved.
REQ-041 Reset mid-operation: arst_i=0 in GAP with 5 bytes queued -> m_valid_o=0, data_read_en_o=0 immediately; after release, the next byte is received correctly; repeat with rst_soft_i for the synchronous case.
